// File: rtl/data_memory_responder.sv
// Single-port byte-addressable data RAM with optional zero-fill after reset.
// Ports: clk, rst, valid/we/addr/width/data_wr request in; data_rd, busy, fault out.
package data_memory_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_access_width_t;
endpackage

module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int          DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 we,
  input  logic [31:0]          addr,
  input  memory_access_width_t width,
  input  logic [31:0]          data_wr,
  output logic [31:0]          data_rd,
  output logic                 busy,
  output logic                 fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  typedef enum logic {
    S_CLEAR,
    S_SERVE
  } state_t;

  localparam state_t RST_STATE =
    (CLEAR_ON_RESET != 0) ? S_CLEAR : S_SERVE;

  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic fault_q, fault_d;

  // Read path: raw word captured straight from the array,
  // lane select applied after the register.
  logic [31:0] rd_word_q;
  logic        rd_zero_q, rd_zero_d;
  memory_access_width_t rd_width_q, rd_width_d;
  logic [1:0]  rd_lane_q, rd_lane_d;
  logic        rd_en;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [3:0]  mem_be;
  logic [AW-1:0] mem_idx;
  logic [31:0] mem_wdata;

  logic [31:0]   off;
  logic [1:0]    lane;
  logic [AW-1:0] req_idx;
  logic          range_err;
  logic          align_err;
  logic          width_err;
  logic          req_err;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;

  assign off       = addr - BASE_ADDR;
  assign lane      = off[1:0];
  assign req_idx   = off[AW+1:2];
  assign range_err = |off[31:AW+2];

  always_comb begin
    align_err = 1'b0;
    width_err = 1'b0;
    req_be    = 4'b0000;
    req_wdata = data_wr;
    case (width)
      BYTE: begin
        req_be    = 4'b0001 << lane;
        req_wdata = {4{data_wr[7:0]}};
      end
      HALF: begin
        align_err = lane[0];
        req_be    = lane[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{data_wr[15:0]}};
      end
      WORD: begin
        align_err = |lane;
        req_be    = 4'b1111;
      end
      default: width_err = 1'b1;
    endcase
  end

  assign req_err = range_err | align_err | width_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fault_d    = 1'b0;
    rd_zero_d  = rd_zero_q;
    rd_width_d = rd_width_q;
    rd_lane_d  = rd_lane_q;
    rd_en      = 1'b0;
    mem_be     = 4'b0000;
    mem_idx    = req_idx;
    mem_wdata  = req_wdata;
    case (state_q)
      S_CLEAR: begin
        mem_be    = 4'b1111;
        mem_idx   = cnt_q;
        mem_wdata = 32'h0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == LAST) begin
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (valid) begin
          if (req_err) begin
            fault_d   = 1'b1;
            rd_zero_d = 1'b1;
          end else if (we) begin
            mem_be = req_be;
          end else begin
            rd_en      = 1'b1;
            rd_zero_d  = 1'b0;
            rd_width_d = width;
            rd_lane_d  = lane;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
      rd_zero_q  <= 1'b1;
      rd_width_q <= WORD;
      rd_lane_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      rd_zero_q  <= rd_zero_d;
      rd_width_q <= rd_width_d;
      rd_lane_q  <= rd_lane_d;
    end
  end

  // Array has no reset so it maps onto block RAM with byte enables.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) begin
        mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (rd_en) begin
      rd_word_q <= mem_q[mem_idx];
    end
  end

  always_comb begin
    data_rd = 32'h0;
    if (!rd_zero_q) begin
      case (rd_width_q)
        BYTE: data_rd = {24'h0, rd_word_q[8*rd_lane_q +: 8]};
        HALF: data_rd = {16'h0, rd_lane_q[1] ? rd_word_q[31:16]
                                            : rd_word_q[15:0]};
        default: data_rd = rd_word_q;
      endcase
    end
  end

  assign busy  = (state_q == S_CLEAR);
  assign fault = fault_q;

endmodule
